// File: rtl/vga_write_queue.sv
// vga_write_queue: buffers processor display stores and drains them
// into the framebuffer write port whenever scan-out grants it.
module vga_write_queue #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_ADDR = 307199
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         vga_wren_enable,
   input  logic [ADDR_W-1:0]            vga_data_addr,
   input  logic [DATA_W-1:0]            vga_data_write,
   input  logic                         fb_grant,
   output logic                         fb_wren,
   output logic [ADDR_W-1:0]            fb_addr,
   output logic [DATA_W-1:0]            fb_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic [7:0]                   drop_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
   localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);
   localparam logic [7:0]        DROP_MAX = 8'hFF;

   // storage
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   // state
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [LVL_W-1:0]  cnt_q,  cnt_d;
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q,  ovf_d;
   logic [7:0]        drop_q, drop_d;

   // per-cycle events
   logic in_range;
   logic push_req;
   logic range_drop;
   logic have_data;
   logic pop;
   logic has_room;
   logic push_acc;
   logic reject;
   logic drop_evt;

   // Classify the incoming store and the drain opportunity.
   always_comb begin
      in_range   = (vga_data_addr <= MAX_A);
      push_req   = vga_wren_enable & in_range;
      range_drop = vga_wren_enable & ~in_range;
      have_data  = (cnt_q != '0);
      pop        = fb_grant & have_data;
      has_room   = (cnt_q < DEPTH_L);
      // a pop on the same edge frees the head slot even when full
      push_acc   = push_req & (has_room | pop);
      reject     = push_req & ~push_acc;
      drop_evt   = range_drop | reject;
   end

   // Next-state for pointers, occupancy, output port and drop accounting.
   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      wren_d = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;

      if (pop) begin
         wren_d = 1'b1;
         addr_d = addr_mem[rptr_q];
         data_d = data_mem[rptr_q];
         rptr_d = rptr_q + PTR_W'(1);
      end

      if (push_acc) begin
         wptr_d = wptr_q + PTR_W'(1);
      end

      unique case ({push_acc, pop})
         2'b10:   cnt_d = cnt_q + LVL_W'(1);
         2'b01:   cnt_d = cnt_q - LVL_W'(1);
         default: cnt_d = cnt_q;
      endcase

      if (reject) begin
         ovf_d = 1'b1;
      end

      if (drop_evt && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State register with synchronous reset that overrides all events.
   always_ff @(posedge clock) begin
      if (reset) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         wren_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         wren_q <= wren_d;
         addr_q <= addr_d;
         data_q <= data_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   // Entry storage; stale contents are harmless since reset clears pointers.
   always_ff @(posedge clock) begin
      if (push_acc && !reset) begin
         addr_mem[wptr_q] <= vga_data_addr;
         data_mem[wptr_q] <= vga_data_write;
      end
   end

   assign fb_wren    = wren_q;
   assign fb_addr    = addr_q;
   assign fb_data    = data_q;
   assign level      = cnt_q;
   assign full       = (cnt_q == DEPTH_L);
   assign empty      = (cnt_q == '0);
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_write_queue.sv
// tb_vga_write_queue: queue-based reference model, per-cycle compare,
// directed scenarios with literal pins, then randomized traffic.
module tb_vga_write_queue;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int MAXA   = 307199;

   typedef struct {
      int addr;
      int data;
   } ent_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              wren  = 1'b0;
   logic [ADDR_W-1:0] addr  = '0;
   logic [DATA_W-1:0] data  = '0;
   logic              grant = 1'b0;
   logic              fb_wren;
   logic [ADDR_W-1:0] fb_addr;
   logic [DATA_W-1:0] fb_data;
   logic              full;
   logic              empty;
   logic [4:0]        level;
   logic              overflow;
   logic [7:0]        drop_count;

   int tests = 0;
   int fails = 0;

   // reference model state
   ent_t m_q[$];
   bit   m_wren;
   int   m_addr, m_data, m_drop;
   bit   m_ovf;
   bit   started = 1'b0;

   // writes actually emitted by the DUT
   ent_t log_q[$];

   vga_write_queue #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(MAXA)
   ) dut (
      .clock(clock), .reset(reset),
      .vga_wren_enable(wren), .vga_data_addr(addr),
      .vga_data_write(data), .fb_grant(grant),
      .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
      .full(full), .empty(empty), .level(level),
      .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   function automatic void chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endfunction

   // Model: FIFO semantics from the rules, one edge at a time.
   always @(posedge clock) begin
      if (reset) begin
         started = 1'b1;
         m_q.delete();
         m_wren = 1'b0;
         m_addr = 0;
         m_data = 0;
         m_ovf  = 1'b0;
         m_drop = 0;
      end else if (started) begin
         if (grant && m_q.size() > 0) begin
            ent_t e;
            e = m_q.pop_front();
            m_wren = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
         end else begin
            m_wren = 1'b0;
         end
         if (wren) begin
            if (int'(addr) > MAXA) begin
               if (m_drop < 255) m_drop++;
            end else if (m_q.size() < DEPTH) begin
               m_q.push_back('{int'(addr), int'(data)});
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
      end
   end

   // Compare: every cycle once the model has seen reset.
   always @(negedge clock) begin
      if (started) begin
         chk("fb_wren", int'(fb_wren), int'(m_wren));
         chk("fb_addr", int'(fb_addr), m_addr);
         chk("fb_data", int'(fb_data), m_data);
         chk("level", int'(level), m_q.size());
         chk("full", int'(full), int'(m_q.size() == DEPTH));
         chk("empty", int'(empty), int'(m_q.size() == 0));
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("drop_count", int'(drop_count), m_drop);
         if (fb_wren) log_q.push_back('{int'(fb_addr), int'(fb_data)});
      end
   end

   task automatic drv(input bit w, input int a, input int d,
                      input bit g, input bit r);
      @(negedge clock);
      wren  = w;
      addr  = ADDR_W'(a);
      data  = DATA_W'(d);
      grant = g;
      reset = r;
   endtask

   task automatic after_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      bit seen;

      // reset
      drv(0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 1);
      after_edge();
      chk("rst_level", int'(level), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_wren", int'(fb_wren), 0);

      // single store, grant high
      drv(0, 0, 0, 1, 0);
      drv(1, 'h10, 'hAB, 1, 0);
      after_edge();
      chk("one_lvl1", int'(level), 1);
      chk("one_nowr", int'(fb_wren), 0);
      drv(0, 0, 0, 1, 0);
      after_edge();
      chk("one_wren", int'(fb_wren), 1);
      chk("one_addr", int'(fb_addr), 'h10);
      chk("one_data", int'(fb_data), 'hAB);
      chk("one_empty", int'(empty), 1);
      drv(0, 0, 0, 1, 0);
      after_edge();
      chk("one_pulse", int'(fb_wren), 0);

      // fill with grant low
      log_q.delete();
      for (int k = 0; k < 16; k++) drv(1, k, k, 0, 0);
      after_edge();
      chk("fill_full", int'(full), 1);
      chk("fill_lvl", int'(level), 16);
      chk("fill_nowr", log_q.size(), 0);

      // overflow drop
      drv(1, 100, 'h64, 0, 0);
      after_edge();
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_drop", int'(drop_count), 1);

      // push while full with a simultaneous pop
      drv(1, 200, 'hC8, 1, 0);
      after_edge();
      chk("fp_lvl", int'(level), 16);
      for (int k = 0; k < 18; k++) drv(0, 0, 0, 1, 0);
      after_edge();
      chk("drain_n", log_q.size(), 17);
      n = 0;
      seen = 0;
      foreach (log_q[i]) begin
         if (i < 16 && log_q[i].addr == i && log_q[i].data == i) n++;
         if (log_q[i].addr == 100) seen = 1;
      end
      chk("drain_order", n, 16);
      chk("drain_no100", int'(seen), 0);
      if (log_q.size() == 17) chk("drain_last", log_q[16].addr, 200);
      chk("drain_empty", int'(empty), 1);

      // address range boundary
      drv(0, 0, 0, 0, 1);
      log_q.delete();
      drv(1, 307200, 'h11, 0, 0);
      after_edge();
      chk("oor_drop", int'(drop_count), 1);
      chk("oor_ovf", int'(overflow), 0);
      chk("oor_lvl", int'(level), 0);
      drv(1, 307199, 'h5A, 1, 0);
      drv(0, 0, 0, 1, 0);
      after_edge();
      chk("max_addr", int'(fb_addr), 307199);
      chk("max_wren", int'(fb_wren), 1);

      // reset mid-drain
      for (int k = 0; k < 9; k++) drv(1, 1000 + k, k, 0, 0);
      drv(0, 0, 0, 1, 0);
      after_edge();
      chk("pre_rst_wren", int'(fb_wren), 1);
      drv(1, 5, 5, 1, 1);
      after_edge();
      chk("mrst_wren", int'(fb_wren), 0);
      chk("mrst_lvl", int'(level), 0);
      chk("mrst_drop", int'(drop_count), 0);
      log_q.delete();
      for (int k = 0; k < 5; k++) drv(0, 0, 0, 1, 0);
      after_edge();
      chk("mrst_silent", log_q.size(), 0);

      // drop counter saturation
      for (int k = 0; k < 300; k++) drv(1, k, k, 0, 0);
      after_edge();
      chk("sat_drop", int'(drop_count), 255);
      drv(0, 0, 0, 0, 1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         int a;
         a = ($urandom_range(0, 9) == 0) ?
             int'($urandom_range(307200, 524287)) :
             int'($urandom_range(0, MAXA));
         drv($urandom_range(0, 9) < 7, a, $urandom_range(0, 255),
             $urandom_range(0, 9) < (c % 400 < 200 ? 3 : 8),
             $urandom_range(0, 999) == 0);
      end
      drv(0, 0, 0, 1, 0);
      drv(0, 0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
